// File: rtl/vxe_vpu_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// vxe_vpu_cmd_dispatch
//   Initiator side of the VPU execution-unit dispatch protocol. Accepts
//   commands from the control unit, decodes each to REGU, PROD or ACTF and
//   issues a one-cycle disp pulse on a shared registered command bus. Keeps
//   one outstanding command per unit, with its owning thread, so that a
//   second command to a thread waits for the first one's done.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   i_vld/o_rdy                command handshake (o_rdy is combinational)
//   i_op, i_th, i_pl           command opcode, thread, payload
//   o_cmd_op/th/pl             shared command bus, valid during a disp cycle
//   o_<u>_disp, i_<u>_done     per-unit dispatch / completion pulses
//   o_busy                     any unit outstanding (registered)
//   o_err                      one-cycle pulse: illegal opcode or spurious done
//   o_stat_disp, o_stat_stall  only when VXE_VPU_DISP_STATS_EN is defined
//
// Configuration
//   VXE_VPU_DISP_STATS_EN : adds wrapping 32-bit disp and stall counters.
//
// Opcodes mirror the control unit encoding (CU_CMD_*):
//   NOP=0 SETACC=1 SETVL=2 SETEN=3 SETRS=4 SETRT=5 SETRD=6 PROD=7 ACTF=8
// ---------------------------------------------------------------------------
module vxe_vpu_cmd_dispatch #(
  parameter int unsigned NTHREADS = 8,
  parameter int unsigned PL_W     = 48,
  parameter int unsigned TH_W     = $clog2(NTHREADS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic [4:0]      i_op,
  input  logic [TH_W-1:0] i_th,
  input  logic [PL_W-1:0] i_pl,
  output logic [4:0]      o_cmd_op,
  output logic [TH_W-1:0] o_cmd_th,
  output logic [PL_W-1:0] o_cmd_pl,
  output logic            o_regu_disp,
  input  logic            i_regu_done,
  output logic            o_prod_disp,
  input  logic            i_prod_done,
  output logic            o_actf_disp,
  input  logic            i_actf_done,
  output logic            o_busy,
  output logic            o_err
`ifdef VXE_VPU_DISP_STATS_EN
  ,
  output logic [31:0]     o_stat_disp,
  output logic [31:0]     o_stat_stall
`endif
);

  localparam int unsigned NUNITS = 3;

  localparam logic [4:0] CU_CMD_NOP    = 5'h00;
  localparam logic [4:0] CU_CMD_SETACC = 5'h01;
  localparam logic [4:0] CU_CMD_SETVL  = 5'h02;
  localparam logic [4:0] CU_CMD_SETEN  = 5'h03;
  localparam logic [4:0] CU_CMD_SETRS  = 5'h04;
  localparam logic [4:0] CU_CMD_SETRT  = 5'h05;
  localparam logic [4:0] CU_CMD_SETRD  = 5'h06;
  localparam logic [4:0] CU_CMD_PROD   = 5'h07;
  localparam logic [4:0] CU_CMD_ACTF   = 5'h08;

  // Unit vector bit order: [0]=REGU [1]=PROD [2]=ACTF
  logic [NUNITS-1:0]            u_busy_q, u_busy_d;
  logic [NUNITS-1:0][TH_W-1:0]  u_th_q, u_th_d;
  logic [NUNITS-1:0]            disp_q, disp_d;
  logic [4:0]                   cmd_op_q, cmd_op_d;
  logic [TH_W-1:0]              cmd_th_q, cmd_th_d;
  logic [PL_W-1:0]              cmd_pl_q, cmd_pl_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;

  logic [NUNITS-1:0]            done_c, u_busy_eff_c, tgt_c;
  logic                         th_busy_eff_c, illegal_c, spurious_c, rdy_c, acc_c;

  // Decode, done bypass, ready and next-state computation
  always_comb begin
    done_c        = {i_actf_done, i_prod_done, i_regu_done};
    u_busy_eff_c  = u_busy_q & ~done_c;
    spurious_c    = |(done_c & ~u_busy_q);

    th_busy_eff_c = 1'b0;
    for (int u = 0; u < int'(NUNITS); u++) begin
      if (u_busy_eff_c[u] && (u_th_q[u] == i_th)) th_busy_eff_c = 1'b1;
    end

    tgt_c     = '0;
    illegal_c = 1'b0;
    case (i_op)
      CU_CMD_SETACC, CU_CMD_SETVL, CU_CMD_SETEN,
      CU_CMD_SETRS,  CU_CMD_SETRT, CU_CMD_SETRD: tgt_c = 3'b001;
      CU_CMD_PROD:                               tgt_c = 3'b010;
      CU_CMD_ACTF:                               tgt_c = 3'b100;
      CU_CMD_NOP:                                tgt_c = 3'b000;
      default:                                   illegal_c = 1'b1;
    endcase

    // NOP and illegal opcodes have no target bit, so they wait on the thread only
    rdy_c = ~(th_busy_eff_c | (|(tgt_c & u_busy_eff_c)));
    acc_c = i_vld & rdy_c;

    disp_d   = acc_c ? tgt_c : '0;
    u_busy_d = u_busy_eff_c | disp_d;
    u_th_d   = u_th_q;
    for (int u = 0; u < int'(NUNITS); u++) begin
      if (disp_d[u]) u_th_d[u] = i_th;
    end

    cmd_op_d = '0;
    cmd_th_d = '0;
    cmd_pl_d = '0;
    if (|disp_d) begin
      cmd_op_d = i_op;
      cmd_th_d = i_th;
      cmd_pl_d = i_pl;
    end

    err_d  = spurious_c | (acc_c & illegal_c);
    busy_d = |u_busy_d;
  end

  // Scoreboard and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      u_busy_q <= '0;
      u_th_q   <= '0;
      disp_q   <= '0;
      cmd_op_q <= '0;
      cmd_th_q <= '0;
      cmd_pl_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      u_busy_q <= u_busy_d;
      u_th_q   <= u_th_d;
      disp_q   <= disp_d;
      cmd_op_q <= cmd_op_d;
      cmd_th_q <= cmd_th_d;
      cmd_pl_q <= cmd_pl_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign o_rdy       = rdy_c;
  assign o_regu_disp = disp_q[0];
  assign o_prod_disp = disp_q[1];
  assign o_actf_disp = disp_q[2];
  assign o_cmd_op    = cmd_op_q;
  assign o_cmd_th    = cmd_th_q;
  assign o_cmd_pl    = cmd_pl_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

`ifdef VXE_VPU_DISP_STATS_EN
  logic [31:0] stat_disp_q, stat_disp_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Disp counted at the accepting edge so it is visible alongside the pulse
  always_comb begin
    stat_disp_d  = stat_disp_q + 32'(|disp_d);
    stat_stall_d = stat_stall_q + 32'(i_vld & ~rdy_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_disp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_disp_q  <= stat_disp_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign o_stat_disp  = stat_disp_q;
  assign o_stat_stall = stat_stall_q;
`endif

endmodule
